// File: rtl/scoreboard_queue.sv
// rtl/scoreboard_queue.sv - in-order issue / out-of-order writeback / in-order commit scoreboard
//
// Purpose:
//   Circular buffer of NR_ENTRIES slots. The issue stage allocates the slot at
//   the tail. Functional units write results back by transaction id in any
//   order. The commit stage retires the head slot once its result is present.
//   The block also tracks which architectural registers have a pending writer
//   (clobber), reports the live entry count, and supports a full flush.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), synchronous active-high reset
//   flush_i                      discard every live entry
//   issue_valid_i/issue_ready_o  allocation handshake; issue_pc_i, issue_rd_i payload
//   issue_trans_id_o             id of the slot that would be allocated (tail)
//   wb_valid_i/wb_trans_id_i/wb_result_i/wb_ex_i
//                                per-port writeback, port k at [k*W +: W]
//   commit_valid_o/commit_ack_i  retire handshake for the head slot
//   commit_pc_o/rd_o/result_o/ex_o  head slot contents (zero when head is free)
//   clobber_o                    bit r set when a live entry targets register r (r != 0)
//   usage_o                      live entry count

module scoreboard_queue #(
  parameter int NR_ENTRIES    = 4,
  parameter int NR_WB_PORTS   = 3,
  parameter int DATA_WIDTH    = 64,
  parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   issue_valid_i,
  output logic                                   issue_ready_o,
  input  logic [DATA_WIDTH-1:0]                  issue_pc_i,
  input  logic [4:0]                             issue_rd_i,
  output logic [TRANS_ID_BITS-1:0]               issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS*DATA_WIDTH-1:0]      wb_result_i,
  input  logic [NR_WB_PORTS-1:0]                 wb_ex_i,
  output logic                                   commit_valid_o,
  input  logic                                   commit_ack_i,
  output logic [DATA_WIDTH-1:0]                  commit_pc_o,
  output logic [4:0]                             commit_rd_o,
  output logic [DATA_WIDTH-1:0]                  commit_result_o,
  output logic                                   commit_ex_o,
  output logic [31:0]                            clobber_o,
  output logic [TRANS_ID_BITS:0]                 usage_o
);

  localparam int T = TRANS_ID_BITS;

  // Control state
  logic [T-1:0]            head_q, head_d;
  logic [T-1:0]            tail_q, tail_d;
  logic [T:0]              count_q, count_d;
  logic [NR_ENTRIES-1:0]   busy_q, busy_d;
  logic [NR_ENTRIES-1:0]   done_q, done_d;
  logic [NR_ENTRIES-1:0]   ex_q, ex_d;

  // Payload storage (no reset needed: only observed while the slot is busy)
  logic [DATA_WIDTH-1:0]   pc_q     [NR_ENTRIES];
  logic [DATA_WIDTH-1:0]   pc_d     [NR_ENTRIES];
  logic [4:0]              rd_q     [NR_ENTRIES];
  logic [4:0]              rd_d     [NR_ENTRIES];
  logic [DATA_WIDTH-1:0]   result_q [NR_ENTRIES];
  logic [DATA_WIDTH-1:0]   result_d [NR_ENTRIES];

  logic head_busy;
  logic issue_fire;
  logic commit_fire;

  assign head_busy        = busy_q[head_q];
  assign issue_ready_o    = (count_q != (T+1)'(NR_ENTRIES));
  assign issue_trans_id_o = tail_q;
  assign usage_o          = count_q;

  assign commit_valid_o   = head_busy & done_q[head_q];
  assign commit_pc_o      = head_busy ? pc_q[head_q]     : '0;
  assign commit_rd_o      = head_busy ? rd_q[head_q]     : '0;
  assign commit_result_o  = head_busy ? result_q[head_q] : '0;
  assign commit_ex_o      = head_busy & ex_q[head_q];

  assign issue_fire  = issue_valid_i & issue_ready_o;
  assign commit_fire = commit_valid_o & commit_ack_i;

  // Clobber is derived from registered slot state, so it follows issue and
  // commit by one cycle without extra storage.
  always_comb begin
    clobber_o = '0;
    for (int e = 0; e < NR_ENTRIES; e++) begin
      if (busy_q[e]) begin
        clobber_o[rd_q[e]] = 1'b1;
      end
    end
    clobber_o[0] = 1'b0;
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ex_d     = ex_q;
    pc_d     = pc_q;
    rd_d     = rd_q;
    result_d = result_q;

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      done_d  = '0;
      ex_d    = '0;
    end else begin
      // Ports are scanned from highest to lowest so the lowest index is the
      // last assignment and wins when several ports target the same slot.
      // Gating on busy_q means a slot allocated this cycle cannot be hit.
      for (int e = 0; e < NR_ENTRIES; e++) begin
        for (int k = NR_WB_PORTS - 1; k >= 0; k--) begin
          if (wb_valid_i[k] && (wb_trans_id_i[k*T +: T] == T'(e)) &&
              busy_q[e] && !done_q[e]) begin
            done_d[e]   = 1'b1;
            result_d[e] = wb_result_i[k*DATA_WIDTH +: DATA_WIDTH];
            ex_d[e]     = wb_ex_i[k];
          end
        end
      end

      if (commit_fire) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + T'(1);
      end

      // The tail slot is never the committing head here: issue needs a free
      // slot, so tail == head only when the queue is empty.
      if (issue_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        ex_d[tail_q]   = 1'b0;
        pc_d[tail_q]   = issue_pc_i;
        rd_d[tail_q]   = issue_rd_i;
        tail_d         = tail_q + T'(1);
      end

      case ({issue_fire, commit_fire})
        2'b10:   count_d = count_q + (T+1)'(1);
        2'b01:   count_d = count_q - (T+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      ex_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ex_q    <= ex_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q     <= pc_d;
    rd_q     <= rd_d;
    result_q <= result_d;
  end

endmodule

// File: tb/tb_scoreboard_queue.sv
// tb/tb_scoreboard_queue.sv - self-checking bench for scoreboard_queue
module tb_scoreboard_queue;

  localparam int N = 4;
  localparam int P = 3;
  localparam int D = 64;
  localparam int T = 2;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           flush_i;
  logic           issue_valid_i;
  logic           issue_ready_o;
  logic [D-1:0]   issue_pc_i;
  logic [4:0]     issue_rd_i;
  logic [T-1:0]   issue_trans_id_o;
  logic [P-1:0]   wb_valid_i;
  logic [P*T-1:0] wb_trans_id_i;
  logic [P*D-1:0] wb_result_i;
  logic [P-1:0]   wb_ex_i;
  logic           commit_valid_o;
  logic           commit_ack_i;
  logic [D-1:0]   commit_pc_o;
  logic [4:0]     commit_rd_o;
  logic [D-1:0]   commit_result_o;
  logic           commit_ex_o;
  logic [31:0]    clobber_o;
  logic [T:0]     usage_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scoreboard_queue #(.NR_ENTRIES(N), .NR_WB_PORTS(P), .DATA_WIDTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_pc_i(issue_pc_i), .issue_rd_i(issue_rd_i),
    .issue_trans_id_o(issue_trans_id_o),
    .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
    .wb_result_i(wb_result_i), .wb_ex_i(wb_ex_i),
    .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i),
    .commit_pc_o(commit_pc_o), .commit_rd_o(commit_rd_o),
    .commit_result_o(commit_result_o), .commit_ex_o(commit_ex_o),
    .clobber_o(clobber_o), .usage_o(usage_o)
  );

  // Reference model: list of live instructions in program order.
  typedef struct {
    int           id;
    logic [D-1:0] pc;
    logic [4:0]   rd;
    bit           done;
    logic [D-1:0] result;
    bit           ex;
  } entry_t;

  entry_t m_q[$];
  int     m_next = 0;

  function automatic logic [31:0] m_clobber();
    logic [31:0] c = '0;
    foreach (m_q[i]) if (m_q[i].rd != 0) c[m_q[i].rd] = 1'b1;
    return c;
  endfunction

  task automatic idle();
    rst_i = 0; flush_i = 0; issue_valid_i = 0; commit_ack_i = 0;
    wb_valid_i = '0; wb_ex_i = '0;
  endtask

  task automatic set_wb(int k, int id, logic [D-1:0] r, bit ex);
    wb_valid_i[k]          = 1'b1;
    wb_trans_id_i[k*T +: T] = T'(id);
    wb_result_i[k*D +: D]   = r;
    wb_ex_i[k]             = ex;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic cycle();
    bit cv, rdy;
    int id;
    if (rst_i || flush_i) begin
      m_q.delete();
      m_next = 0;
    end else begin
      cv  = (m_q.size() > 0) && m_q[0].done;
      rdy = (m_q.size() != N);
      for (int k = 0; k < P; k++) begin
        if (wb_valid_i[k]) begin
          id = int'(wb_trans_id_i[k*T +: T]);
          foreach (m_q[i]) begin
            if (m_q[i].id == id && !m_q[i].done) begin
              m_q[i].done   = 1;
              m_q[i].result = wb_result_i[k*D +: D];
              m_q[i].ex     = wb_ex_i[k];
            end
          end
        end
      end
      if (cv && commit_ack_i) void'(m_q.pop_front());
      if (issue_valid_i && rdy) begin
        m_q.push_back('{id: m_next, pc: issue_pc_i, rd: issue_rd_i,
                        done: 0, result: '0, ex: 0});
        m_next = (m_next + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(logic [D-1:0] pc, logic [4:0] rd);
    issue_valid_i = 1; issue_pc_i = pc; issue_rd_i = rd;
    cycle();
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    cycle();
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", issue_ready_o); end
    checks++; if (commit_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cvalid got %b exp 0", commit_valid_o); end
    checks++; if (clobber_o !== 32'h0) begin errors++; $display("FAIL reset_clobber got %h exp 0", clobber_o); end
    checks++; if (usage_o !== 3'd0) begin errors++; $display("FAIL reset_usage got %0d exp 0", usage_o); end
    checks++; if (issue_trans_id_o !== 2'd0) begin errors++; $display("FAIL reset_tid got %0d exp 0", issue_trans_id_o); end
  endtask

  task automatic test_first_issue();
    issue(64'h100, 5'd5);
    checks++; if (clobber_o !== 32'h20) begin errors++; $display("FAIL first_clobber got %h exp 20", clobber_o); end
    checks++; if (usage_o !== 3'd1) begin errors++; $display("FAIL first_usage got %0d exp 1", usage_o); end
    checks++; if (commit_valid_o !== 1'b0) begin errors++; $display("FAIL first_cvalid got %b exp 0", commit_valid_o); end
    checks++; if (commit_pc_o !== 64'h100) begin errors++; $display("FAIL first_cpc got %h exp 100", commit_pc_o); end
  endtask

  task automatic test_fill();
    issue(64'h104, 5'd1);
    issue(64'h108, 5'd2);
    issue(64'h10c, 5'd3);
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", issue_ready_o); end
    checks++; if (usage_o !== 3'd4) begin errors++; $display("FAIL full_usage got %0d exp 4", usage_o); end
    set_wb(0, 0, 64'h55, 0);
    cycle();
    checks++; if (commit_result_o !== 64'h55) begin errors++; $display("FAIL full_cres got %h exp 55", commit_result_o); end
    issue_valid_i = 1; issue_pc_i = 64'hdead; issue_rd_i = 5'd9; commit_ack_i = 1;
    cycle();
    checks++; if (usage_o !== 3'd3) begin errors++; $display("FAIL full_ack_usage got %0d exp 3", usage_o); end
    checks++; if (issue_trans_id_o !== 2'd0) begin errors++; $display("FAIL full_ack_tid got %0d exp 0", issue_trans_id_o); end
    checks++; if (clobber_o[9] !== 1'b0) begin errors++; $display("FAIL full_ignored_clobber got %b exp 0", clobber_o[9]); end
    flush_i = 1;
    cycle();
  endtask

  task automatic test_out_of_order();
    logic [D-1:0] exp_res [3];
    exp_res[0] = 64'hB; exp_res[1] = 64'hC; exp_res[2] = 64'hA;
    issue(64'h200, 5'd8);
    issue(64'h204, 5'd9);
    issue(64'h208, 5'd10);
    set_wb(1, 2, 64'hA, 0);
    cycle();
    checks++; if (commit_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_early_cvalid got %b exp 0", commit_valid_o); end
    set_wb(0, 0, 64'hB, 0);
    cycle();
    checks++; if (commit_valid_o !== 1'b1) begin errors++; $display("FAIL ooo_cvalid got %b exp 1", commit_valid_o); end
    set_wb(2, 1, 64'hC, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (commit_result_o !== exp_res[i]) begin errors++; $display("FAIL ooo_res%0d got %h exp %h", i, commit_result_o, exp_res[i]); end
      commit_ack_i = 1;
      cycle();
    end
    checks++; if (usage_o !== 3'd0) begin errors++; $display("FAIL ooo_usage got %0d exp 0", usage_o); end
  endtask

  task automatic test_port_priority();
    flush_i = 1;
    cycle();
    issue(64'h300, 5'd4);
    issue(64'h304, 5'd6);
    set_wb(0, 1, 64'h11, 0);
    set_wb(2, 1, 64'h22, 1);
    set_wb(1, 0, 64'h33, 0);
    cycle();
    checks++; if (commit_result_o !== 64'h33) begin errors++; $display("FAIL prio_head got %h exp 33", commit_result_o); end
    commit_ack_i = 1;
    cycle();
    checks++; if (commit_result_o !== 64'h11) begin errors++; $display("FAIL prio_res got %h exp 11", commit_result_o); end
    checks++; if (commit_ex_o !== 1'b0) begin errors++; $display("FAIL prio_ex got %b exp 0", commit_ex_o); end
    commit_ack_i = 1;
    cycle();
  endtask

  task automatic test_clobber();
    flush_i = 1;
    cycle();
    issue(64'h400, 5'd0);
    checks++; if (clobber_o !== 32'h0) begin errors++; $display("FAIL clob_rd0 got %h exp 0", clobber_o); end
    issue(64'h404, 5'd7);
    issue(64'h408, 5'd7);
    checks++; if (clobber_o !== 32'h80) begin errors++; $display("FAIL clob_two got %h exp 80", clobber_o); end
    set_wb(0, 0, 64'h1, 0);
    set_wb(1, 1, 64'h2, 0);
    cycle();
    commit_ack_i = 1;
    cycle();
    commit_ack_i = 1;
    cycle();
    checks++; if (clobber_o !== 32'h80) begin errors++; $display("FAIL clob_keep got %h exp 80", clobber_o); end
  endtask

  task automatic test_flush_wrap();
    flush_i = 1;
    cycle();
    issue(64'h500, 5'd1);
    issue(64'h504, 5'd2);
    issue(64'h508, 5'd3);
    set_wb(0, 0, 64'h9, 0);
    cycle();
    flush_i = 1; issue_valid_i = 1; issue_pc_i = 64'h50c; issue_rd_i = 5'd4; commit_ack_i = 1;
    cycle();
    checks++; if (usage_o !== 3'd0) begin errors++; $display("FAIL flush_usage got %0d exp 0", usage_o); end
    checks++; if (clobber_o !== 32'h0) begin errors++; $display("FAIL flush_clobber got %h exp 0", clobber_o); end
    checks++; if (issue_trans_id_o !== 2'd0) begin errors++; $display("FAIL flush_tid got %0d exp 0", issue_trans_id_o); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (issue_trans_id_o !== T'(i % N)) begin errors++; $display("FAIL wrap_tid%0d got %0d exp %0d", i, issue_trans_id_o, i % N); end
      issue(64'h600 + 64'(i * 4), 5'(i + 1));
      set_wb(i % P, i % N, 64'(i * 3), 0);
      cycle();
      checks++; if (commit_pc_o !== 64'h600 + 64'(i * 4)) begin errors++; $display("FAIL wrap_pc%0d got %h exp %h", i, commit_pc_o, 64'h600 + 64'(i * 4)); end
      checks++; if (commit_result_o !== 64'(i * 3)) begin errors++; $display("FAIL wrap_res%0d got %h exp %h", i, commit_result_o, 64'(i * 3)); end
      commit_ack_i = 1;
      cycle();
    end
    checks++; if (usage_o !== 3'd0) begin errors++; $display("FAIL wrap_usage got %0d exp 0", usage_o); end
  endtask

  task automatic test_random();
    bit           exp_cv;
    logic [D-1:0] exp_pc, exp_res;
    logic [4:0]   exp_rd;
    bit           exp_ex;
    for (int n = 0; n < 600; n++) begin
      rst_i         = ($urandom_range(0, 199) == 0);
      flush_i       = ($urandom_range(0, 39) == 0);
      issue_valid_i = ($urandom_range(0, 9) < 6);
      issue_pc_i    = {$urandom, $urandom};
      issue_rd_i    = 5'($urandom);
      commit_ack_i  = ($urandom_range(0, 9) < 5);
      for (int k = 0; k < P; k++) begin
        if ($urandom_range(0, 2) == 0)
          set_wb(k, $urandom_range(0, N - 1), {$urandom, $urandom}, 1'($urandom));
      end
      cycle();
      exp_cv = 0; exp_pc = '0; exp_rd = '0; exp_res = '0; exp_ex = 0;
      if (m_q.size() > 0) begin
        exp_pc = m_q[0].pc;
        exp_rd = m_q[0].rd;
        if (m_q[0].done) begin
          exp_cv = 1; exp_res = m_q[0].result; exp_ex = m_q[0].ex;
        end
      end
      checks++; if (usage_o !== (T+1)'(m_q.size())) begin errors++; $display("FAIL rnd_usage@%0d got %0d exp %0d", n, usage_o, m_q.size()); end
      checks++; if (issue_ready_o !== (m_q.size() != N)) begin errors++; $display("FAIL rnd_ready@%0d got %b exp %b", n, issue_ready_o, m_q.size() != N); end
      checks++; if (issue_trans_id_o !== T'(m_next)) begin errors++; $display("FAIL rnd_tid@%0d got %0d exp %0d", n, issue_trans_id_o, m_next); end
      checks++; if (clobber_o !== m_clobber()) begin errors++; $display("FAIL rnd_clobber@%0d got %h exp %h", n, clobber_o, m_clobber()); end
      checks++; if (commit_valid_o !== exp_cv) begin errors++; $display("FAIL rnd_cvalid@%0d got %b exp %b", n, commit_valid_o, exp_cv); end
      checks++; if (commit_pc_o !== exp_pc) begin errors++; $display("FAIL rnd_cpc@%0d got %h exp %h", n, commit_pc_o, exp_pc); end
      checks++; if (commit_rd_o !== exp_rd) begin errors++; $display("FAIL rnd_crd@%0d got %0d exp %0d", n, commit_rd_o, exp_rd); end
      if (exp_cv) begin
        checks++; if (commit_result_o !== exp_res) begin errors++; $display("FAIL rnd_cres@%0d got %h exp %h", n, commit_result_o, exp_res); end
        checks++; if (commit_ex_o !== exp_ex) begin errors++; $display("FAIL rnd_cex@%0d got %b exp %b", n, commit_ex_o, exp_ex); end
      end
    end
  endtask

  initial begin
    issue_pc_i = '0; issue_rd_i = '0; wb_trans_id_i = '0; wb_result_i = '0;
    idle();
    rst_i = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_first_issue();
    test_fill();
    test_out_of_order();
    test_port_priority();
    test_clobber();
    test_flush_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
